// File: rtl/spm_dpram_be.sv
// spm_dpram_be: dual-port word RAM with per-byte write enables.
//
// Both ports share one clock. Each port reads on every access and also
// writes the byte lanes whose be bit is set. The read result registers at
// the access edge (latency 1), or one edge later when OUT_REG=1.
//
// Ports:
//   clk                 single clock, rising edge
//   reset               synchronous, active-low; clears outputs, blocks writes
//   ena/enb             port access strobes
//   bea/beb             byte write enables (all zero = read only)
//   addra/addrb         word addresses
//   dia/dib             write data
//   doa/dob             read data (held while the port is idle)
//   vala/valb           read data valid
//   coll                one-cycle pulse after a same-address write/write
//
// RAM contents are not reset.
module spm_dpram_be #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned OUT_REG  = 0,
    parameter int unsigned RDW_MODE = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ena,
    input  logic [DATA_W/8-1:0] bea,
    input  logic [ADDR_W-1:0]   addra,
    input  logic [DATA_W-1:0]   dia,
    output logic [DATA_W-1:0]   doa,
    output logic                vala,
    input  logic                enb,
    input  logic [DATA_W/8-1:0] beb,
    input  logic [ADDR_W-1:0]   addrb,
    input  logic [DATA_W-1:0]   dib,
    output logic [DATA_W-1:0]   dob,
    output logic                valb,
    output logic                coll
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] rd_a, rd_b;
    logic              coll_now;

    logic [DATA_W-1:0] s1_doa, s1_dob;
    logic              s1_vala, s1_valb;

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                                input logic [DATA_W-1:0] new_w,
                                                input logic [NB-1:0]     be);
        logic [DATA_W-1:0] r;
        r = old_w;
        for (int unsigned i = 0; i < NB; i++) begin
            if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

    // Cross-port reads always see the pre-write word; only a port's own
    // write can be forwarded, and only in write-first mode.
    always_comb begin
        rd_a = mem[addra];
        rd_b = mem[addrb];
        if (RDW_MODE != 0) begin
            rd_a = merge(mem[addra], dia, bea);
            rd_b = merge(mem[addrb], dib, beb);
        end
        coll_now = ena && enb && (addra == addrb) && (|bea) && (|beb);
    end

    // Port A is written after port B so that, on a shared address, port A
    // owns every lane both ports enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (enb && beb[i]) mem[addrb][8*i +: 8] <= dib[8*i +: 8];
                if (ena && bea[i]) mem[addra][8*i +: 8] <= dia[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_doa  <= '0;
            s1_dob  <= '0;
            s1_vala <= 1'b0;
            s1_valb <= 1'b0;
            coll    <= 1'b0;
        end else begin
            s1_vala <= ena;
            s1_valb <= enb;
            if (ena) s1_doa <= rd_a;
            if (enb) s1_dob <= rd_b;
            coll    <= coll_now;
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic [DATA_W-1:0] s2_doa, s2_dob;
        logic              s2_vala, s2_valb;

        always_ff @(posedge clk) begin
            if (!reset) begin
                s2_doa  <= '0;
                s2_dob  <= '0;
                s2_vala <= 1'b0;
                s2_valb <= 1'b0;
            end else begin
                s2_doa  <= s1_doa;
                s2_dob  <= s1_dob;
                s2_vala <= s1_vala;
                s2_valb <= s1_valb;
            end
        end

        assign doa  = s2_doa;
        assign dob  = s2_dob;
        assign vala = s2_vala;
        assign valb = s2_valb;
    end else begin : g_noreg
        assign doa  = s1_doa;
        assign dob  = s1_dob;
        assign vala = s1_vala;
        assign valb = s1_valb;
    end

endmodule

// File: tb/tb_spm_dpram_be.sv
// Directed bench for spm_dpram_be. Two instances share all inputs:
// dut0 uses OUT_REG=0/RDW_MODE=0, dut1 uses OUT_REG=1/RDW_MODE=1.
module tb_spm_dpram_be;

    logic        clk = 1'b0;
    logic        reset;
    logic        ena, enb;
    logic [3:0]  bea, beb;
    logic [11:0] addra, addrb;
    logic [31:0] dia, dib;

    logic [31:0] doa0, dob0, doa1, dob1;
    logic        vala0, valb0, coll0, vala1, valb1, coll1;

    int checks = 0;
    int errors = 0;

    logic [31:0] wv [4];

    always #5 clk = ~clk;

    spm_dpram_be #(.DATA_W(32), .ADDR_W(12), .OUT_REG(0), .RDW_MODE(0)) dut0 (
        .clk(clk), .reset(reset),
        .ena(ena), .bea(bea), .addra(addra), .dia(dia), .doa(doa0), .vala(vala0),
        .enb(enb), .beb(beb), .addrb(addrb), .dib(dib), .dob(dob0), .valb(valb0),
        .coll(coll0)
    );

    spm_dpram_be #(.DATA_W(32), .ADDR_W(12), .OUT_REG(1), .RDW_MODE(1)) dut1 (
        .clk(clk), .reset(reset),
        .ena(ena), .bea(bea), .addra(addra), .dia(dia), .doa(doa1), .vala(vala1),
        .enb(enb), .beb(beb), .addrb(addrb), .dib(dib), .dob(dob1), .valb(valb1),
        .coll(coll1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ena = 1'b0; enb = 1'b0; bea = 4'h0; beb = 4'h0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_ne(input string tag, input logic [31:0] obs, input logic [31:0] bad);
        checks++;
        assert (obs !== bad) else begin
            errors++;
            $error("FAIL %s: observed %h expected anything but %h", tag, obs, bad);
        end
    endtask

    initial begin
        wv[0] = 32'h10203040;
        wv[1] = 32'h55667788;
        wv[2] = 32'h9ABCDEF0;
        wv[3] = 32'h0F1E2D3C;

        // Reset held with write strobes active: nothing may be written.
        reset = 1'b0;
        ena = 1'b1; enb = 1'b1; bea = 4'hF; beb = 4'hF;
        addra = 12'd0; addrb = 12'd0; dia = 32'hDEADBEEF; dib = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_doa0", doa0, 32'h0);
            chk("rst_dob0", dob0, 32'h0);
            chk("rst_val0", {vala0, valb0, coll0}, 32'h0);
            chk("rst_doa1", doa1, 32'h0);
            chk("rst_val1", {vala1, valb1, coll1}, 32'h0);
        end

        // Access at the release edge is accepted.
        reset = 1'b1;
        bea = 4'h0; beb = 4'h0; enb = 1'b0;
        tick();
        chk_ne("rst_nowrite0", doa0, 32'hDEADBEEF);
        chk("rel_vala0", vala0, 32'h1);
        idle();
        tick();
        chk_ne("rst_nowrite1", doa1, 32'hDEADBEEF);
        chk("rel_vala1", vala1, 32'h1);
        chk("idle_vala0", vala0, 32'h0);

        // Preload words 0..3, clear 7 (port A) and 9 (port B) together.
        for (int i = 0; i < 4; i++) begin
            ena = 1'b1; bea = 4'hF; addra = 12'(i); dia = wv[i];
            tick();
        end
        ena = 1'b1; bea = 4'hF; addra = 12'd7; dia = 32'h0;
        enb = 1'b1; beb = 4'hF; addrb = 12'd9; dib = 32'h0;
        tick();
        idle();
        tick();
        tick();

        // Byte merge on address 5.
        ena = 1'b1; bea = 4'hF; addra = 12'd5; dia = 32'h11223344;
        tick();
        bea = 4'b0101; dia = 32'hAABBCCDD;
        tick();
        bea = 4'h0;
        tick();
        chk("merge_doa0", doa0, 32'h11BB33DD);
        chk("merge_vala0", vala0, 32'h1);
        idle();
        tick();
        chk("merge_vala0_drop", vala0, 32'h0);
        chk("merge_doa0_hold", doa0, 32'h11BB33DD);
        chk("merge_doa1", doa1, 32'h11BB33DD);
        chk("merge_vala1", vala1, 32'h1);
        tick();
        chk("merge_vala1_drop", vala1, 32'h0);

        // Read-during-write at address 7: A writes, B reads.
        ena = 1'b1; bea = 4'hF; addra = 12'd7; dia = 32'hCAFEF00D;
        enb = 1'b1; beb = 4'h0; addrb = 12'd7;
        tick();
        chk("rdw_doa0_oldword", doa0, 32'h0);
        chk("rdw_dob0_cross", dob0, 32'h0);
        chk("rdw_coll0", coll0, 32'h0);
        idle();
        tick();
        chk("rdw_doa1_newword", doa1, 32'hCAFEF00D);
        chk("rdw_dob1_cross", dob1, 32'h0);
        chk("rdw_valb1", valb1, 32'h1);

        // Write/write collision at address 9.
        ena = 1'b1; bea = 4'b0011; addra = 12'd9; dia = 32'hAAAAAAAA;
        enb = 1'b1; beb = 4'b0110; addrb = 12'd9; dib = 32'hBBBBBBBB;
        tick();
        chk("coll0_pulse", coll0, 32'h1);
        chk("coll1_pulse", coll1, 32'h1);
        idle();
        tick();
        chk("coll0_end", coll0, 32'h0);
        chk("coll1_end", coll1, 32'h0);

        // Read/read on the same address: no collision, both see the word.
        ena = 1'b1; bea = 4'h0; addra = 12'd9;
        enb = 1'b1; beb = 4'h0; addrb = 12'd9;
        tick();
        chk("coll_rb_doa0", doa0, 32'h00BBAAAA);
        chk("coll_rb_dob0", dob0, 32'h00BBAAAA);
        chk("rr_nocoll0", coll0, 32'h0);
        idle();
        tick();
        chk("coll_rb_doa1", doa1, 32'h00BBAAAA);
        chk("coll_rb_dob1", dob1, 32'h00BBAAAA);
        chk("rr_nocoll1", coll1, 32'h0);
        tick();

        // Back-to-back reads of 0..3 on port A.
        for (int i = 0; i < 4; i++) begin
            ena = 1'b1; bea = 4'h0; addra = 12'(i);
            tick();
            chk("pipe_doa0", doa0, wv[i]);
            chk("pipe_vala0", vala0, 32'h1);
            if (i > 0) begin
                chk("pipe_doa1", doa1, wv[i-1]);
                chk("pipe_vala1", vala1, 32'h1);
            end else begin
                chk("pipe_vala1_first", vala1, 32'h0);
            end
        end
        idle();
        tick();
        chk("pipe_vala0_end", vala0, 32'h0);
        chk("pipe_doa1_last", doa1, wv[3]);
        chk("pipe_vala1_last", vala1, 32'h1);
        tick();
        chk("pipe_vala1_end", vala1, 32'h0);

        // Reset while a registered read is in flight.
        ena = 1'b1; bea = 4'h0; addra = 12'd2;
        tick();
        chk("mid_doa0", doa0, wv[2]);
        reset = 1'b0;
        idle();
        tick();
        chk("mid_vala1_rst", vala1, 32'h0);
        chk("mid_doa1_rst", doa1, 32'h0);
        reset = 1'b1;
        tick();
        chk("mid_vala1_lost", vala1, 32'h0);

        // Memory survives reset.
        ena = 1'b1; bea = 4'h0; addra = 12'd5;
        enb = 1'b1; beb = 4'h0; addrb = 12'd9;
        tick();
        chk("keep_doa0", doa0, 32'h11BB33DD);
        chk("keep_dob0", dob0, 32'h00BBAAAA);
        idle();
        tick();
        chk("keep_doa1", doa1, 32'h11BB33DD);
        chk("keep_dob1", dob1, 32'h00BBAAAA);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
